// File: rtl/lcd_pkg.sv
// Shared constants, unit string and state encodings for the LCD feeder path.
package lcd_pkg;
  localparam int LCD_WORD_W = 9;

  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DASH   = 8'h2D;

  localparam int UNIT_LEN = 4;
  // " kWh", first character in the top byte
  localparam logic [8*UNIT_LEN-1:0] UNIT_STR = 32'h206B5768;

  typedef enum logic [2:0] {
    IDLE, CHECK, CONVERT, SEND_ADDR, SEND_DIGIT, SEND_UNIT, DONE
  } disp_state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_ACK, TX_DONE} tx_state_t;

  function automatic logic [7:0] unit_char(input logic [1:0] idx);
    return UNIT_STR[8*(UNIT_LEN-1-int'(idx)) +: 8];
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/lcd_word_tx.sv
// Sends one {rs, data} word to the lcd driver over the data_ready / busy_flag handshake.
module lcd_word_tx
  import lcd_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LCD_WORD_W-1:0] word,
  input  logic                  lcd_busy,
  output logic                  done,
  output logic [LCD_WORD_W-1:0] d_in,
  output logic                  data_ready
);
  tx_state_t state, next_state;
  logic busy_q;
  logic [LCD_WORD_W-1:0] word_q;
  logic low_twice;

  // busy_q resets high so a driver still reporting its reset-time 0 needs two clean samples
  assign low_twice = !lcd_busy && !busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= TX_IDLE;
      busy_q <= 1'b1;
      word_q <= '0;
    end else begin
      state  <= next_state;
      busy_q <= lcd_busy;
      if (state == TX_IDLE && next_state == TX_REQ) word_q <= word;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE: if (start && low_twice) next_state = TX_REQ;
      TX_REQ:  next_state = TX_ACK;
      TX_ACK:  if (lcd_busy) next_state = TX_DONE;
      TX_DONE: if (!lcd_busy) next_state = TX_IDLE;
      default: next_state = TX_IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == TX_REQ);
    done       = (state == TX_DONE) && !lcd_busy;
    d_in       = word_q;
  end
endmodule

// File: rtl/energy_display.sv
// Converts a binary energy reading to decimal and streams one right-aligned frame to the lcd driver.
// Define ENERGY_DISPLAY_UNITS_EN to append " kWh" after the digits.
module energy_display
  import lcd_pkg::*;
#(
  parameter int         WIDTH      = 20,
  parameter int         DIGITS     = 7,
  parameter logic [6:0] DDRAM_ADDR = 7'h40
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  value_valid,
  input  logic                  lcd_busy,
  output logic [LCD_WORD_W-1:0] d_in,
  output logic                  data_ready,
  output logic                  frame_busy
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + DIGITS + UNIT_LEN + 1);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  disp_state_t state, next_state;
  logic pending, ovf, seen_nz, too_big, last_digit;
  logic [WIDTH-1:0] pending_value, work;
  logic [BCD_W-1:0] bcd, bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic [3:0] cur_digit;
  logic [7:0] digit_char;
  logic start, word_done;
  logic [LCD_WORD_W-1:0] word;

  assign too_big    = 64'(work) > MAX_VAL;
  assign cur_digit  = bcd[BCD_W-1 -: 4];
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A new strobe wins over the IDLE hand-off so a reading arriving while idle is never lost
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      pending_value <= '0;
      work          <= '0;
      bcd           <= '0;
      ovf           <= 1'b0;
      seen_nz       <= 1'b0;
      cnt           <= '0;
    end else begin
      if (value_valid) begin
        pending       <= 1'b1;
        pending_value <= value;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end
      case (state)
        IDLE: if (pending) work <= pending_value;
        CHECK: begin
          ovf <= too_big;
          bcd <= '0;
          cnt <= '0;
        end
        CONVERT: begin
          {bcd, work} <= {bcd_adj, work} << 1;
          cnt         <= cnt + 1'b1;
        end
        SEND_ADDR: begin
          seen_nz <= 1'b0;
          cnt     <= '0;
        end
        SEND_DIGIT: if (word_done) begin
          bcd <= bcd << 4;
          cnt <= last_digit ? '0 : cnt + 1'b1;
          if (cur_digit != 4'd0) seen_nz <= 1'b1;
        end
`ifdef ENERGY_DISPLAY_UNITS_EN
        SEND_UNIT: if (word_done) cnt <= cnt + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (pending) next_state = CHECK;
      CHECK:      next_state = too_big ? SEND_ADDR : CONVERT;
      CONVERT:    if (cnt == CNT_W'(WIDTH - 1)) next_state = SEND_ADDR;
      SEND_ADDR:  if (word_done) next_state = SEND_DIGIT;
`ifdef ENERGY_DISPLAY_UNITS_EN
      SEND_DIGIT: if (word_done && last_digit) next_state = SEND_UNIT;
      SEND_UNIT:  if (word_done && cnt == CNT_W'(UNIT_LEN - 1)) next_state = DONE;
`else
      SEND_DIGIT: if (word_done && last_digit) next_state = DONE;
`endif
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    if (ovf)                                     digit_char = CH_DASH;
    else if (cur_digit == 4'd0 && !seen_nz && !last_digit) digit_char = CH_SPACE;
    else                                         digit_char = CH_ZERO + {4'h0, cur_digit};
  end

  always_comb begin
    start      = 1'b0;
    word       = '0;
    frame_busy = 1'b0;
    case (state)
      CHECK, CONVERT: frame_busy = 1'b1;
      SEND_ADDR: begin
        frame_busy = 1'b1;
        start      = 1'b1;
        word       = {1'b0, SET_DDRAM | {1'b0, DDRAM_ADDR}};
      end
      SEND_DIGIT: begin
        frame_busy = 1'b1;
        start      = 1'b1;
        word       = {1'b1, digit_char};
      end
`ifdef ENERGY_DISPLAY_UNITS_EN
      SEND_UNIT: begin
        frame_busy = 1'b1;
        start      = 1'b1;
        word       = {1'b1, unit_char(cnt[1:0])};
      end
`endif
      default: ;
    endcase
  end

  lcd_word_tx u_tx (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .word       (word),
    .done       (word_done),
    .d_in       (d_in),
    .data_ready (data_ready),
    .lcd_busy   (lcd_busy)
  );
endmodule

// File: tb/tb_energy_display.sv
// Scoreboard bench for energy_display: a default instance and a 4-digit/16-bit instance,
// each answered by its own busy-flag responder.
module tb_energy_display;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] value0;
  logic        valid0;
  logic        busy0 = 1'b0;
  logic [8:0]  d_in0;
  logic        rdy0, fb0;
  logic [15:0] value1;
  logic        valid1;
  logic        busy1 = 1'b0;
  logic [8:0]  d_in1;
  logic        rdy1, fb1;

  energy_display dut0 (
    .clock(clock), .reset_n(reset_n), .value(value0), .value_valid(valid0),
    .lcd_busy(busy0), .d_in(d_in0), .data_ready(rdy0), .frame_busy(fb0)
  );

  energy_display #(.WIDTH(16), .DIGITS(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .value(value1), .value_valid(valid1),
    .lcd_busy(busy1), .d_in(d_in1), .data_ready(rdy1), .frame_busy(fb1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Driver stand-in: busy rises one cycle after a request and stays up 4 cycles (1000 when hold_long)
  int bcnt0 = 0, bcnt1 = 0;
  bit pend0 = 0, pend1 = 0, hold_long = 0;
  always @(posedge clock) begin
    #1;
    if (bcnt0 > 0) bcnt0--;
    if (pend0) begin pend0 = 0; bcnt0 = hold_long ? 1000 : 4; end
    if (rdy0) pend0 = 1;
    busy0 = (bcnt0 > 0);
    if (bcnt1 > 0) bcnt1--;
    if (pend1) begin pend1 = 0; bcnt1 = 4; end
    if (rdy1) pend1 = 1;
    busy1 = (bcnt1 > 0);
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];
  int checks = 0, errors = 0;
  bit prev0 = 0, prev1 = 0, seen0 = 0, seen1 = 0;
  int first0 = 0, first1 = 0, pulses0 = 0;
  int n, k, p, hi, changes;
  logic [8:0] held;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge and score any word the DUTs handed to the driver
  task automatic step();
    logic [8:0] e;
    @(negedge clock);
    if (rdy0) begin
      pulses0++;
      check_output("rdy0_single_cycle", 32'(prev0), 0);
      if (!seen0) begin seen0 = 1; first0 = cyc; end
      e = (exp0_q.size() > 0) ? exp0_q.pop_front() : 9'h1FF;
      check_output("word0", 32'(d_in0), 32'(e));
    end
    if (rdy1) begin
      check_output("rdy1_single_cycle", 32'(prev1), 0);
      if (!seen1) begin seen1 = 1; first1 = cyc; end
      e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 9'h1FF;
      check_output("word1", 32'(d_in1), 32'(e));
    end
    prev0 = rdy0;
    prev1 = rdy1;
  endtask

  task automatic push_word(input bit sel, input logic [8:0] w);
    if (sel) exp1_q.push_back(w);
    else     exp0_q.push_back(w);
  endtask

  // Expected frame from plain decimal arithmetic
  task automatic push_frame(input bit sel, input int unsigned v, input int ndig);
    int unsigned lim, pw, d;
    bit nz;
    lim = 1;
    for (int i = 0; i < ndig; i++) lim = lim * 10;
    push_word(sel, 9'h0C0);
    pw = lim / 10;
    nz = 0;
    for (int i = 0; i < ndig; i++) begin
      d = (v / pw) % 10;
      if (d != 0) nz = 1;
      if (v >= lim)                   push_word(sel, 9'h12D);
      else if (!nz && i != ndig - 1)  push_word(sel, 9'h120);
      else                            push_word(sel, 9'h130 + 9'(d));
      pw = pw / 10;
    end
`ifdef ENERGY_DISPLAY_UNITS_EN
    push_word(sel, 9'h120);
    push_word(sel, 9'h16B);
    push_word(sel, 9'h157);
    push_word(sel, 9'h168);
`endif
  endtask

  task automatic apply_stimulus(input bit sel, input int unsigned v, output int strobe_cyc);
    if (sel) begin value1 = 16'(v); valid1 = 1'b1; seen1 = 0; end
    else     begin value0 = 20'(v); valid0 = 1'b1; seen0 = 0; end
    step();
    valid0 = 1'b0;
    valid1 = 1'b0;
    strobe_cyc = cyc;
  endtask

  task automatic wait_drain(input int bound);
    int c;
    c = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || fb0 || fb1) && c < bound) begin
      step();
      c++;
    end
    check_output("drain_queue0", 32'(exp0_q.size()), 0);
    check_output("drain_queue1", 32'(exp1_q.size()), 0);
    check_output("frame_busy0_low", 32'(fb0), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; value0 = '0; value1 = '0;
    repeat (3) step();
    check_output("reset_d_in", 32'(d_in0), 0);
    check_output("reset_data_ready", 32'(rdy0), 0);
    check_output("reset_frame_busy", 32'(fb0), 0);
    check_output("reset_d_in_small", 32'(d_in1), 0);
    reset_n = 1'b1;
    repeat (4) step();

    $display("[TB] value 1234");
    exp0_q.push_back(9'h0C0);
    repeat (3) exp0_q.push_back(9'h120);
    exp0_q.push_back(9'h131); exp0_q.push_back(9'h132);
    exp0_q.push_back(9'h133); exp0_q.push_back(9'h134);
`ifdef ENERGY_DISPLAY_UNITS_EN
    exp0_q.push_back(9'h120); exp0_q.push_back(9'h16B);
    exp0_q.push_back(9'h157); exp0_q.push_back(9'h168);
`endif
    apply_stimulus(0, 1234, n);
    wait_drain(2000);
    check_output("latency_after_convert", 32'(first0 >= n + 23), 1);

    $display("[TB] value 0 and full-width maximum");
    push_frame(0, 0, 7);
    apply_stimulus(0, 0, n);
    wait_drain(2000);
    push_frame(0, 1048575, 7);
    apply_stimulus(0, 1048575, n);
    wait_drain(2000);

    $display("[TB] small instance: overflow, top value, overflow");
    push_frame(1, 10000, 4);
    apply_stimulus(1, 10000, n);
    wait_drain(2000);
    check_output("ovf_first_rdy_offset", 32'(first1 - n), 3);
    push_frame(1, 9999, 4);
    apply_stimulus(1, 9999, n);
    wait_drain(2000);
    push_frame(1, 65535, 4);
    apply_stimulus(1, 65535, n);
    wait_drain(2000);

    $display("[TB] strobes 5 then 7 during a frame");
    push_frame(0, 42, 7);
    apply_stimulus(0, 42, n);
    repeat (4) step();
    check_output("frame_busy_mid_frame", 32'(fb0), 1);
    apply_stimulus(0, 5, n);
    repeat (3) step();
    apply_stimulus(0, 7, n);
    push_frame(0, 7, 7);
    wait_drain(3000);
    repeat (60) step();
    check_output("no_extra_frame", 32'(fb0), 0);

    $display("[TB] busy held high for 1000 cycles");
    hold_long = 1;
    p = pulses0;
    push_frame(0, 8, 7);
    apply_stimulus(0, 8, n);
    k = 0;
    while (!seen0 && k < 100) begin step(); k++; end
    check_output("hold_request_seen", 32'(seen0), 1);
    held = d_in0;
    k = 0;
    while (!busy0 && k < 10) begin step(); k++; end
    hold_long = 0;
    hi = 0;
    changes = 0;
    while (busy0 && hi < 1100) begin
      step();
      hi++;
      if (d_in0 !== held) changes++;
    end
    check_output("hold_single_pulse", 32'(pulses0 - p), 1);
    check_output("hold_d_in_stable", 32'(changes), 0);
    wait_drain(2000);

    $display("[TB] reset mid-frame");
    p = pulses0;
    push_frame(0, 999, 7);
    apply_stimulus(0, 999, n);
    k = 0;
    while (pulses0 - p < 3 && k < 500) begin step(); k++; end
    apply_stimulus(0, 55, n);
    check_output("frame_busy_before_reset", 32'(fb0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_d_in", 32'(d_in0), 0);
    check_output("async_reset_data_ready", 32'(rdy0), 0);
    check_output("async_reset_frame_busy", 32'(fb0), 0);
    exp0_q.delete();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (60) step();
    check_output("pending_cleared_by_reset", 32'(fb0), 0);
    push_frame(0, 321, 7);
    apply_stimulus(0, 321, n);
    wait_drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
